// File: rtl/stage4ma_pkg.sv
// rtl/stage4ma_pkg.sv - shared opcodes, flag positions, stage states and WB field bundle
package stage4ma_pkg;

  // Memory opcodes in instr[23:16]; everything else retires straight through
  localparam logic [7:0] OPC_R_ADD = 8'h01;
  localparam logic [7:0] OPC_R_LD  = 8'h10;
  localparam logic [7:0] OPC_I_LDi = 8'h11;
  localparam logic [7:0] OPC_R_ST  = 8'h12;
  localparam logic [7:0] OPC_I_STi = 8'h13;

  // Flag bit positions inside the 4-bit flags word
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  // Memory handshake FSM encoding
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Fields carried unchanged from EX to WB
  typedef struct packed {
    logic [23:0] pc;
    logic [23:0] instr;
    logic [3:0]  tgt_gp;
    logic [3:0]  tgt_sr;
    logic [3:0]  flags;
    logic        branch;
  } wb_t;

  function automatic logic is_ld_op(input logic [7:0] opc);
    return (opc == OPC_R_LD) || (opc == OPC_I_LDi);
  endfunction

  function automatic logic is_st_op(input logic [7:0] opc);
    return (opc == OPC_R_ST) || (opc == OPC_I_STi);
  endfunction

endpackage

// File: rtl/stage4ma_if.sv
// rtl/stage4ma_if.sv - req/ack data-memory port
interface stage4ma_if;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/stage4ma_memctl.sv
// rtl/stage4ma_memctl.sv - memory handshake FSM, timeout counter and request registers
module stage4ma_memctl
  import stage4ma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        is_st_i,
  input  logic [23:0] addr_i,
  input  logic [23:0] wdata_i,
  output logic        wait_o,
  output logic        retire_o,
  output logic [23:0] result_o,
  output logic        fault_o,
  stage4ma_if.master  mem
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic           req_q, req_d;
  logic           we_q, we_d;
  logic [23:0]    addr_q, addr_d;
  logic [23:0]    wdata_q, wdata_d;
  logic           fault_q, fault_d;

  assign cnt_inc = cnt_q + CW'(1);

  // Next state: issue in IDLE, hold request in WAIT until ack or timeout (ack has priority)
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fault_d  = fault_q;
    retire_o = 1'b0;
    result_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = is_st_i;
          addr_d  = addr_i;
          wdata_d = is_st_i ? wdata_i : 24'h0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (mem.mem_ack) begin
          state_d  = ST_IDLE;
          req_d    = 1'b0;
          retire_o = 1'b1;
          result_o = we_q ? addr_q : mem.mem_rdata;
        end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
          state_d  = ST_IDLE;
          req_d    = 1'b0;
          fault_d  = 1'b1;
          retire_o = 1'b1;
          result_o = '0;
        end
      end
    endcase
  end

  // State and request registers; reset drops mem_req at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
    end
  end

  assign wait_o        = (state_q == ST_WAIT);
  assign fault_o       = fault_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: rtl/stage4ma.sv
// rtl/stage4ma.sv - memory-access pipeline stage between EX and WB
module stage4ma
  import stage4ma_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [23:0] RESET_PC       = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_in,
  input  logic [23:0] pc_in,
  input  logic [23:0] instr_in,
  input  logic [3:0]  tgt_gp_in,
  input  logic [3:0]  tgt_sr_in,
  input  logic [23:0] result_in,
  input  logic [3:0]  flags_in,
  input  logic [23:0] store_data_in,
  input  logic        branch_taken_in,
  output logic        stall_out,
  stage4ma_if.master  mem,
  output logic        enable_out,
  output logic [23:0] pc_out,
  output logic [23:0] instr_out,
  output logic [3:0]  tgt_gp_out,
  output logic [3:0]  tgt_sr_out,
  output logic [23:0] result_out,
  output logic [3:0]  flags_out,
  output logic        branch_taken_out,
  output logic        fault_out
);

  localparam wb_t WB_RESET = '{pc: RESET_PC, instr: 24'h0, tgt_gp: 4'h0,
                               tgt_sr: 4'h0, flags: 4'h0, branch: 1'b0};

  logic        is_ld, is_st, is_mem;
  logic        in_wait, start, retire;
  logic [23:0] mem_result;
  wb_t         in_fields;
  wb_t         hold_q, hold_d;
  wb_t         wb_q, wb_d;
  logic [23:0] res_q, res_d;
  logic        en_q, en_d;

  assign is_ld     = is_ld_op(instr_in[23:16]);
  assign is_st     = is_st_op(instr_in[23:16]);
  assign is_mem    = enable_in & (is_ld | is_st);
  assign start     = !in_wait & is_mem;
  assign stall_out = in_wait | (!in_wait & is_mem);
  assign in_fields = '{pc: pc_in, instr: instr_in, tgt_gp: tgt_gp_in,
                       tgt_sr: tgt_sr_in, flags: flags_in, branch: branch_taken_in};

  stage4ma_memctl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_memctl (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .is_st_i  (is_st),
    .addr_i   (result_in),
    .wdata_i  (store_data_in),
    .wait_o   (in_wait),
    .retire_o (retire),
    .result_o (mem_result),
    .fault_o  (fault_out),
    .mem      (mem)
  );

  // Capture the memory instruction's pass-through fields while it waits on memory
  always_comb begin
    hold_d = hold_q;
    if (start) hold_d = in_fields;
  end

  // WB latch: retire a finished memory op, or a non-memory op straight from EX
  always_comb begin
    wb_d  = wb_q;
    res_d = res_q;
    en_d  = 1'b0;
    if (retire) begin
      wb_d  = hold_q;
      res_d = mem_result;
      en_d  = 1'b1;
    end else if (!in_wait && enable_in && !is_mem) begin
      wb_d  = in_fields;
      res_d = result_in;
      en_d  = 1'b1;
    end
  end

  // Holding and WB registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      wb_q   <= WB_RESET;
      res_q  <= '0;
      en_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      wb_q   <= wb_d;
      res_q  <= res_d;
      en_q   <= en_d;
    end
  end

  assign enable_out       = en_q;
  assign pc_out           = wb_q.pc;
  assign instr_out        = wb_q.instr;
  assign tgt_gp_out       = wb_q.tgt_gp;
  assign tgt_sr_out       = wb_q.tgt_sr;
  assign flags_out        = wb_q.flags;
  assign branch_taken_out = wb_q.branch;
  assign result_out       = res_q;

endmodule

// File: doc/stage4ma.md
Name: stage4ma

Overview:
- Memory-access pipeline stage. Sits directly downstream of the execute stage and upstream of write-back.
- Consumes the EX latch outputs: result (used as the effective address), store data, flags, the branch flag and register indices.
- Performs load/store transactions on a req/ack data-memory port and stalls upstream while a transaction is outstanding.
- Latches the retired instruction for write-back. For loads, the retired result is the memory read data.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT without mem_ack before a fault is raised. Must be ≥1; counter width is clog2(TIMEOUT_CYCLES+1).
- RESET_PC, 24'h000000: reset value of pc_out.

Ports:
- clk  in  1  Pipeline clock; all state updates on the rising edge.
- rst  in  1  Reset, asynchronous and active-high.
- enable_in  in  1  Valid instruction from EX.
- pc_in  in  24  Instruction PC.
- instr_in  in  24  Instruction word; opcode in [23:16].
- tgt_gp_in  in  4  GP target register index.
- tgt_sr_in  in  4  SR target register index.
- result_in  in  24  EX result; effective address for LD/LDi/ST/STi.
- flags_in  in  4  EX flags (Z/C/N/V).
- store_data_in  in  24  Store data.
- branch_taken_in  in  1  Branch taken flag from EX.
- stall_out  out  1  Upstream must hold all inputs and its latches while high.
- mem_req  out  1  Memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  24  Word address.
- mem_wdata  out  24  Write data.
- mem_rdata  in  24  Read data; valid when mem_ack is high.
- mem_ack  in  1  One-cycle completion pulse.
- enable_out  out  1  Valid to WB; high for exactly one cycle per retired instruction.
- pc_out  out  24  Latched pc_in.
- instr_out  out  24  Latched instr_in.
- tgt_gp_out  out  4  Latched tgt_gp_in.
- tgt_sr_out  out  4  Latched tgt_sr_in.
- result_out  out  24  Retired result.
- flags_out  out  4  Latched flags_in, passed through unchanged (loads do not alter flags).
- branch_taken_out  out  1  Latched branch_taken_in.
- fault_out  out  1  Sticky memory-timeout fault.

Behaviour:
- Reset values:
  - All outputs 0, except pc_out = RESET_PC.
  - FSM goes to IDLE; timeout counter cleared.
  - mem_req drops immediately, even mid-transaction; any in-flight ack after reset is ignored.
- Classification: is_ld = opcode ∈ {OPC_R_LD, OPC_I_LDi}; is_st = opcode ∈ {OPC_R_ST, OPC_I_STi}; is_mem = enable_in & (is_ld | is_st).
- stall_out (combinational) = (state==WAIT) | (state==IDLE & is_mem).
- IDLE state:
  - If enable_in & !is_mem: on the next edge, latch all pass-through fields, result_out = result_in, enable_out = 1. Latency 1 cycle.
  - If is_mem: on the next edge, register mem_req = 1, mem_we = is_st, mem_addr = result_in, mem_wdata = store_data_in (0 for loads). Capture pc/instr/tgt/flags/branch into holding registers, clear the counter, go to WAIT; enable_out = 0.
  - If !enable_in: enable_out = 0; all other outputs hold.
- WAIT state:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable; the counter increments each cycle.
  - On mem_ack: deassert mem_req and latch the held fields to the outputs. result_out = mem_rdata for a load, or mem_addr for a store. enable_out = 1 on the next cycle; go to IDLE.
  - Minimum load/store latency is 2 cycles (request cycle, then ack cycle). Back-to-back memory ops are accepted in the IDLE cycle following retirement.
  - Timeout: if the counter reaches TIMEOUT_CYCLES with no ack, deassert mem_req, set fault_out = 1 (cleared only by rst), retire with result_out = 0 and enable_out = 1, and go to IDLE.
  - If ack and timeout occur in the same cycle, ack wins and no fault is raised.
- mem_ack seen in IDLE is ignored.
- Inputs are sampled only in IDLE. Changes while stall_out = 1 are a protocol violation by upstream and have no effect.

Decomposition:
- Opcode constants come from the shared opcodes header; flag bit positions from the shared flags header.
- FSM state encoding (IDLE = 1'b0, WAIT = 1'b1) lives in a new shared stage-constants header.
- The memory handshake FSM, counter and request registers form one natural sub-module, stage4ma_memctl. The top level keeps classification and the WB latches.

Test Plan:
- Reset release: assert rst mid-WAIT → mem_req = 0 the same cycle, all outputs 0, pc_out = RESET_PC, fault_out = 0.
- ADD pass-through: enable_in = 1, result_in = 24'h00ABCD, flags_in = 4'b0010 → one cycle later enable_out = 1, result_out = 24'h00ABCD, flags_out = 4'b0010, stall_out never high.
- LD with ack after 3 cycles: result_in = 24'h000100, mem_rdata = 24'h123456 → mem_req = 1, mem_we = 0, mem_addr = 24'h000100 held for 3 cycles, stall_out high throughout, then result_out = 24'h123456, enable_out pulses once.
- ST with immediate ack: result_in = 24'h000200, store_data_in = 24'h0000FF → mem_we = 1, mem_wdata = 24'h0000FF, ack next cycle, result_out = 24'h000200.
- Timeout: TIMEOUT_CYCLES = 4, no ack → mem_req drops after 4 WAIT cycles, fault_out = 1 and stays high, result_out = 0, enable_out = 1.
- Edge cases:
  - Ack and timeout in the same cycle → normal retire, fault_out = 0.
  - Spurious ack in IDLE → no change.
  - Back-to-back LD, ST → two separate transactions, with exactly two enable_out pulses.
